// File: rtl/trig_pkg.sv
// Shared trigger-bit indices, record layout and record FSM states for the layer trigger recorder.
package trig_pkg;

    localparam int TRIG_BITS  = 8;
    localparam int TRIG_IDX_W = $clog2(TRIG_BITS);
    localparam int REC_TS_W   = 56;

    localparam int B_ALL_LAYERS = 0;
    localparam int B_COLUMN     = 1;
    localparam int B_SPREAD     = 2;
    localparam int B_ADJACENT   = 3;
    localparam int B_LAYER_THR  = 4;
    localparam int B_ANY_HIT    = 5;
    localparam int B_HIT_THR    = 6;
    localparam int B_EXTERNAL   = 7;

    typedef struct packed {
        logic [TRIG_BITS-1:0] bits;
        logic [REC_TS_W-1:0]  ts;
    } trig_rec_t;

    typedef enum logic [1:0] {
        REC_IDLE  = 2'd0,
        REC_OPEN  = 2'd1,
        REC_CLOSE = 2'd2
    } rec_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [TRIG_IDX_W-1:0] lowest_bit(input logic [TRIG_BITS-1:0] m);
        lowest_bit = '0;
        for (int i = TRIG_BITS - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = TRIG_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/trig_record_fifo.sv
// First-word-fall-through record FIFO with valid/ready pop, occupancy count and sticky drop flag.
module trig_record_fifo
    import trig_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_adc,
    input  logic                       nrst,
    input  logic                       clear,
    input  logic                       push,
    input  trig_rec_t                  push_rec,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output trig_rec_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trig_rec_t        mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = rd_ready && !empty && !clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !clear && (!full || do_pop);

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && !do_push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (do_push) mem_q[wr_q] <= push_rec;
    end

    assign rd_valid = !empty;
    assign head     = empty ? '0 : mem_q[rd_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/layer_trigger_recorder.sv
// Layer/bar coincidence trigger: stretchers, two-stage condition pipeline, per-bit deadtime,
// output pulse and a timestamped record FSM feeding the readout FIFO.
module layer_trigger_recorder
    import trig_pkg::*;
#(
    parameter int N_LAYERS   = 4,
    parameter int N_BARS     = 8,
    parameter int CNT_W      = 6,
    parameter int ACTIVE_MIN = 2,
    parameter int OUT_LEN    = 16,
    parameter int TS_W       = REC_TS_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_adc,
    input  logic                          nrst,
    input  logic [N_LAYERS*N_BARS-1:0]    hit_in,
    input  logic                          ext_trig,
    input  logic                          daq_ready,
    input  logic                          pass_prescale,
    input  logic [TRIG_BITS-1:0]          trig_enable,
    input  logic [CNT_W-1:0]              coincidence_time,
    input  logic [7:0]                    dead_time,
    input  logic [7:0]                    layer_threshold,
    input  logic [7:0]                    hit_threshold,
    input  logic [TS_W-1:0]               timestamp,
    input  logic                          hold_record,
    input  logic                          clear,
    output logic                          trig_out,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [TRIG_BITS-1:0]          rec_bits,
    output logic [TS_W-1:0]               rec_time,
    output logic [$clog2(FIFO_DEPTH):0]   rec_count,
    output logic                          overflow
);

    localparam int N_CH  = N_LAYERS * N_BARS;
    localparam int LC_W  = $clog2(N_BARS + 1);
    localparam int CC_W  = $clog2(N_LAYERS + 1);
    localparam int TC_W  = $clog2(N_CH + 1);
    localparam int OUT_W = $clog2(OUT_LEN + 1);

    logic [CNT_W-1:0]     cnt_q [N_CH];
    logic [N_CH-1:0]      active;
    logic [LC_W-1:0]      layer_sum [N_LAYERS], layer_cnt_q [N_LAYERS];
    logic [CC_W-1:0]      col_sum [N_BARS], col_cnt_q [N_BARS];
    logic [TC_W-1:0]      total_sum, total_cnt_q;
    logic [1:0]           ext_q;
    logic [N_LAYERS-1:0]  layer_hit;
    logic [CC_W-1:0]      n_layers;
    logic                 col3, spread, adj;
    logic [TRIG_BITS-1:0] flags_d, flags_q, fire, dead_nz;
    logic [7:0]           dead_q [TRIG_BITS];
    logic                 pulse_q;
    logic [OUT_W-1:0]     out_cnt_q;

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (hit_in[c])           cnt_q[c] <= coincidence_time;
                else if (cnt_q[c] != '0) cnt_q[c] <= cnt_q[c] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) active[c] = int'(cnt_q[c]) > ACTIVE_MIN;
    end

    always_comb begin
        for (int l = 0; l < N_LAYERS; l++) layer_sum[l] = '0;
        for (int b = 0; b < N_BARS; b++)   col_sum[b]   = '0;
        total_sum = '0;
        for (int l = 0; l < N_LAYERS; l++) begin
            for (int b = 0; b < N_BARS; b++) begin
                if (active[l*N_BARS + b]) begin
                    layer_sum[l] = layer_sum[l] + 1'b1;
                    col_sum[b]   = col_sum[b] + 1'b1;
                    total_sum    = total_sum + 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_layers = '0;
        col3     = 1'b0;
        spread   = 1'b0;
        adj      = 1'b0;
        for (int l = 0; l < N_LAYERS; l++) layer_hit[l] = (layer_cnt_q[l] != '0);
        for (int l = 0; l < N_LAYERS; l++) n_layers = n_layers + CC_W'(layer_hit[l]);
        for (int b = 0; b < N_BARS; b++) if (col_cnt_q[b] >= CC_W'(3)) col3 = 1'b1;
        for (int i = 0; i < N_LAYERS; i++) begin
            for (int j = i + 2; j < N_LAYERS; j++) if (layer_hit[i] && layer_hit[j]) spread = 1'b1;
        end
        for (int i = 0; i + 1 < N_LAYERS; i++) if (layer_hit[i] && layer_hit[i+1]) adj = 1'b1;
        flags_d               = '0;
        flags_d[B_ALL_LAYERS] = &layer_hit;
        flags_d[B_COLUMN]     = col3;
        flags_d[B_SPREAD]     = spread;
        flags_d[B_ADJACENT]   = adj;
        flags_d[B_LAYER_THR]  = int'(n_layers) >= int'(layer_threshold);
        flags_d[B_ANY_HIT]    = (total_cnt_q != '0);
        flags_d[B_HIT_THR]    = int'(total_cnt_q) > int'(hit_threshold);
        flags_d[B_EXTERNAL]   = ext_q[1];
    end

    // ext_trig takes two register stages so it meets the flags from hits sampled on the same edge.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int l = 0; l < N_LAYERS; l++) layer_cnt_q[l] <= '0;
            for (int b = 0; b < N_BARS; b++)   col_cnt_q[b]   <= '0;
            total_cnt_q <= '0;
            ext_q       <= '0;
            flags_q     <= '0;
        end else begin
            for (int l = 0; l < N_LAYERS; l++) layer_cnt_q[l] <= layer_sum[l];
            for (int b = 0; b < N_BARS; b++)   col_cnt_q[b]   <= col_sum[b];
            total_cnt_q <= total_sum;
            ext_q       <= {ext_q[0], ext_trig};
            flags_q     <= flags_d;
        end
    end

    always_comb begin
        for (int b = 0; b < TRIG_BITS; b++) dead_nz[b] = (dead_q[b] != '0);
    end

    assign fire = trig_enable & flags_q & ~dead_nz & {TRIG_BITS{daq_ready && pass_prescale}};

    // Only a fire with every bit out of deadtime starts a new output pulse.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int b = 0; b < TRIG_BITS; b++) dead_q[b] <= '0;
            pulse_q   <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            for (int b = 0; b < TRIG_BITS; b++) begin
                if (fire[b])         dead_q[b] <= dead_time;
                else if (dead_nz[b]) dead_q[b] <= dead_q[b] - 1'b1;
            end
            pulse_q <= (|fire) && !(|dead_nz);
            if (pulse_q)                out_cnt_q <= OUT_W'(OUT_LEN);
            else if (out_cnt_q != '0)   out_cnt_q <= out_cnt_q - 1'b1;
        end
    end

    assign trig_out = (out_cnt_q != '0);

    rec_state_e                state_q, state_d;
    logic [TRIG_BITS-1:0]      bits_q, bits_d, pending_q, pending_d, open_mask;
    logic [TRIG_IDX_W-1:0]     first_q, first_d;
    logic [REC_TS_W-1:0]       ts_q, ts_d;
    logic                      push;
    trig_rec_t                 push_rec, head;

    assign open_mask = fire | pending_q;

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) state_q <= REC_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REC_IDLE:  if (|open_mask) state_d = REC_OPEN;
            REC_OPEN:  if (dead_q[first_q] == '0 && !hold_record) state_d = REC_CLOSE;
            REC_CLOSE: state_d = REC_IDLE;
            default:   state_d = REC_IDLE;
        endcase
        if (clear) state_d = REC_IDLE;
    end

    // A fire landing in the CLOSE cycle is parked in pending and opens the next record.
    always_comb begin
        bits_d    = bits_q;
        first_d   = first_q;
        ts_d      = ts_q;
        pending_d = pending_q;
        push      = 1'b0;
        case (state_q)
            REC_IDLE: begin
                if (|open_mask) begin
                    bits_d    = open_mask;
                    first_d   = lowest_bit(open_mask);
                    ts_d      = REC_TS_W'(timestamp);
                    pending_d = '0;
                end
            end
            REC_OPEN:  bits_d = bits_q | fire;
            REC_CLOSE: begin
                push      = 1'b1;
                pending_d = fire;
            end
            default: ;
        endcase
        if (clear) begin
            bits_d    = '0;
            pending_d = '0;
            push      = 1'b0;
        end
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            bits_q    <= '0;
            first_q   <= '0;
            ts_q      <= '0;
            pending_q <= '0;
        end else begin
            bits_q    <= bits_d;
            first_q   <= first_d;
            ts_q      <= ts_d;
            pending_q <= pending_d;
        end
    end

    assign push_rec.bits = bits_q;
    assign push_rec.ts   = ts_q;

    trig_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_adc  (clk_adc),
        .nrst     (nrst),
        .clear    (clear),
        .push     (push),
        .push_rec (push_rec),
        .rd_ready (rec_ready),
        .rd_valid (rec_valid),
        .head     (head),
        .count    (rec_count),
        .overflow (overflow)
    );

    assign rec_bits = head.bits;
    assign rec_time = TS_W'(head.ts);

endmodule
